// File: rtl/recovery_controller.sv
// Fault-recovery sequencer: checkpoints the retiring PC, flushes, pulses a PC restore, then verifies or escalates to FATAL.
// Optional lifetime fault statistics are built when RECOVERY_STATS_EN is defined.
module recovery_controller #(
   parameter int unsigned MAX_RETRY    = 3,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fault_detected,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic        clear_fatal,
   output logic        recovery_en,
   output logic [31:0] pc_saved,
   output logic        pipeline_stall,
   output logic [3:0]  retry_count,
   output logic        fatal_error,
   output logic [2:0]  state_o,
   output logic [15:0] fault_count
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FLUSH   = 3'd1,
      RECOVER = 3'd2,
      VERIFY  = 3'd3,
      FATAL   = 3'd4
   } state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRY);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  flush_cnt;
   logic [3:0]  flush_cnt_nxt;
   logic [31:0] pc_nxt;
   logic [3:0]  retry_nxt;
   logic [3:0]  retry_inc;

   assign retry_inc = (retry_count == 4'hF) ? retry_count : retry_count + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         flush_cnt   <= 4'd0;
         pc_saved    <= RESET_PC;
         retry_count <= 4'd0;
      end else begin
         state       <= state_nxt;
         flush_cnt   <= flush_cnt_nxt;
         pc_saved    <= pc_nxt;
         retry_count <= retry_nxt;
      end
   end

   // Faults take priority over commits; FLUSH and RECOVER ignore both inputs.
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      pc_nxt        = pc_saved;
      retry_nxt     = retry_count;
      case (state)
         IDLE: begin
            if (fault_detected) begin
               state_nxt     = FLUSH;
               flush_cnt_nxt = FLUSH_LOAD;
               retry_nxt     = retry_inc;
            end else if (commit_valid) begin
               pc_nxt = commit_pc;
            end
         end
         FLUSH: begin
            if (flush_cnt == 4'd0) begin
               state_nxt = RECOVER;
            end else begin
               flush_cnt_nxt = flush_cnt - 4'd1;
            end
         end
         RECOVER: state_nxt = VERIFY;
         VERIFY: begin
            if (fault_detected) begin
               if (retry_count == RETRY_MAX) begin
                  state_nxt = FATAL;
               end else begin
                  state_nxt     = FLUSH;
                  flush_cnt_nxt = FLUSH_LOAD;
                  retry_nxt     = retry_inc;
               end
            end else if (commit_valid) begin
               pc_nxt    = commit_pc;
               retry_nxt = 4'd0;
               state_nxt = IDLE;
            end
         end
         FATAL: begin
            if (clear_fatal) begin
               state_nxt = IDLE;
               retry_nxt = 4'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control outputs depend on the state register alone.
   assign recovery_en    = (state == RECOVER);
   assign pipeline_stall = (state == FLUSH) || (state == RECOVER) || (state == FATAL);
   assign fatal_error    = (state == FATAL);
   assign state_o        = state;

`ifdef RECOVERY_STATS_EN
   logic        fault_accept;
   logic [15:0] fault_cnt;

   assign fault_accept = fault_detected && ((state == IDLE) || (state == VERIFY));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_cnt <= 16'h0000;
      end else if (fault_accept && (fault_cnt != 16'hFFFF)) begin
         fault_cnt <= fault_cnt + 16'd1;
      end
   end

   assign fault_count = fault_cnt;
`else
   assign fault_count = 16'h0000;
`endif

endmodule

// File: tb/tb_recovery_controller.sv
// Scoreboard bench for recovery_controller: a rule-level model predicts every post-edge output set,
// a monitor pops and compares each cycle. Define RECOVERY_STATS_EN to expect live fault statistics.
module tb_recovery_controller;

   localparam int MAXR = 3;
   localparam int FLC  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fault_detected = 1'b0;
   logic        commit_valid = 1'b0;
   logic [31:0] commit_pc = 32'h0;
   logic        clear_fatal = 1'b0;
   logic        recovery_en;
   logic [31:0] pc_saved;
   logic        pipeline_stall;
   logic [3:0]  retry_count;
   logic        fatal_error;
   logic [2:0]  state_o;
   logic [15:0] fault_count;

   recovery_controller #(.MAX_RETRY(MAXR), .FLUSH_CYCLES(FLC), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .fault_detected(fault_detected), .commit_valid(commit_valid),
      .commit_pc(commit_pc), .clear_fatal(clear_fatal), .recovery_en(recovery_en),
      .pc_saved(pc_saved), .pipeline_stall(pipeline_stall), .retry_count(retry_count),
      .fatal_error(fatal_error), .state_o(state_o), .fault_count(fault_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned st;
      int unsigned pc;
      int unsigned rc;
      int unsigned fc;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int failures = 0;

   // Reference model: mode 0..4 = idle, flush, recover, verify, fatal.
   int unsigned m_mode, m_left, m_pc, m_retry, m_fc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic compare(input exp_t e);
      chk("state", 32'(state_o), e.st);
      chk("recovery_en", 32'(recovery_en), (e.st == 2) ? 1 : 0);
      chk("pipeline_stall", 32'(pipeline_stall), (e.st == 1 || e.st == 2 || e.st == 4) ? 1 : 0);
      chk("fatal_error", 32'(fatal_error), (e.st == 4) ? 1 : 0);
      chk("pc_saved", pc_saved, e.pc);
      chk("retry_count", 32'(retry_count), e.rc);
      chk("fault_count", 32'(fault_count), e.fc);
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      e.st = m_mode; e.pc = m_pc; e.rc = m_retry; e.fc = m_fc;
      return e;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_left = 0; m_pc = 0; m_retry = 0; m_fc = 0;
   endtask

   task automatic count_fault();
`ifdef RECOVERY_STATS_EN
      if (m_fc < 16'hFFFF) m_fc++;
`endif
   endtask

   task automatic model_step(input bit f, input bit c, input int unsigned pc, input bit clr);
      case (m_mode)
         0: if (f) begin
               count_fault(); m_retry++; m_left = FLC; m_mode = 1;
            end else if (c) m_pc = pc;
         1: begin
               m_left--;
               if (m_left == 0) m_mode = 2;
            end
         2: m_mode = 3;
         3: if (f) begin
               count_fault();
               if (m_retry == MAXR) m_mode = 4;
               else begin m_retry++; m_left = FLC; m_mode = 1; end
            end else if (c) begin
               m_pc = pc; m_retry = 0; m_mode = 0;
            end
         default: if (clr) begin m_mode = 0; m_retry = 0; end
      endcase
   endtask

   task automatic cycle(input bit f, input bit c, input logic [31:0] pc, input bit clr);
      @(negedge clk);
      fault_detected = f; commit_valid = c; commit_pc = pc; clear_fatal = clr;
      model_step(f, c, pc, clr);
      exp_q.push_back(snapshot());
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      fault_detected = 1'b0; commit_valid = 1'b0; clear_fatal = 1'b0;
      model_reset();
      #1;
      compare(snapshot());
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_to_verify();
      for (int i = 0; i < 40 && m_mode != 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
      chk("reach_verify", m_mode, 3);
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) compare(exp_q.pop_front());
      end
   end

   initial begin : driver
      model_reset();
      #2;
      compare(snapshot());
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Checkpoint, single fault episode, verify commit
      cycle(1'b0, 1'b1, 32'h100, 1'b0);
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      run_to_verify();
      cycle(1'b0, 1'b1, 32'h104, 1'b0);

      // Retry exhaustion into FATAL, then release
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < MAXR; k++) begin
         run_to_verify();
         cycle(1'b1, 1'b1, 32'h300 + 32'(k), 1'b0);
      end
      chk("fatal_reached", m_mode, 4);
      repeat (3) cycle(1'b1, 1'b1, 32'h3F0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // Fault and commit together in IDLE
      cycle(1'b1, 1'b1, 32'h200, 1'b0);
      cycle(1'b0, 1'b1, 32'h204, 1'b0);

      // Reset in the middle of FLUSH, then quiet cycles
      do_reset();
      repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);

      // Five accepted faults from a clean start
      do_reset();
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 1'b0, 32'h0, 1'b0);
         run_to_verify();
         cycle(1'b0, 1'b1, 32'h400 + 32'(4 * k), 1'b0);
      end

      // Randomized traffic with occasional asynchronous resets
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         else cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) == 0);
      end

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/recovery_controller.md
RECOVERY_CONTROLLER -- requirements
Module: recovery_controller

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, meaning retries allowed before fatal (legal 1..15).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, meaning stall cycles before PC restore (legal 1..15).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning checkpoint value after reset.
REQ-004 One clock; reset is asynchronous and active-low. Ports: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-005 SHALL have port fault_detected  input 1  fault flag from the detection logic.
REQ-006 SHALL have port commit_valid  input 1  instruction retired without fault this cycle.
REQ-007 SHALL have port commit_pc  input 32  PC of the retiring instruction.
REQ-008 SHALL have port clear_fatal  input 1  software/debug release from the fatal state.
REQ-009 SHALL have port recovery_en  output 1  one-cycle restore pulse to the downstream PC-restore stage.
REQ-010 SHALL have port pc_saved  output 32  checkpoint PC to the downstream PC-restore stage.
REQ-011 SHALL have port pipeline_stall  output 1  holds fetch/decode.
REQ-012 SHALL have port retry_count  output 4  retries of the current fault episode.
REQ-013 SHALL have port fatal_error  output 1  retry budget exhausted.
REQ-014 SHALL have port state_o  output 3  current FSM encoding (IDLE=0, FLUSH=1, RECOVER=2, VERIFY=3, FATAL=4).
REQ-015 SHALL have port fault_count  output 16  lifetime fault counter (see Configuration).

Function
REQ-016 IDLE: when commit_valid=1, pc_saved SHALL load commit_pc at the next edge; when fault_detected=1, the FSM SHALL go to FLUSH and retry_count SHALL increment.
REQ-017 IDLE, fault_detected and commit_valid in the same cycle: the fault wins and pc_saved SHALL NOT update.
REQ-018 FLUSH: pipeline_stall=1 and recovery_en=0 for exactly FLUSH_CYCLES cycles, counted by an internal down-counter; the FSM SHALL then go to RECOVER.
REQ-019 RECOVER: recovery_en=1 and pipeline_stall=1 for exactly one cycle; the FSM SHALL then go to VERIFY.
REQ-020 VERIFY: pipeline_stall=0. On commit_valid, pc_saved SHALL load commit_pc, retry_count SHALL clear, and the FSM SHALL go to IDLE.
REQ-021 VERIFY, on fault_detected: if retry_count==MAX_RETRY, the FSM SHALL go to FATAL; otherwise it SHALL go to FLUSH and retry_count SHALL increment. A fault coincident with commit_valid SHALL win, and pc_saved SHALL be unchanged.
REQ-022 fault_detected and commit_valid SHALL be ignored in FLUSH and RECOVER; pc_saved SHALL be stable from FLUSH entry until VERIFY exit.
REQ-023 FATAL: fatal_error=1, pipeline_stall=1, recovery_en=0. The FSM SHALL stay in FATAL until clear_fatal=1, then go to IDLE with retry_count=0. pc_saved SHALL be retained.
REQ-024 All outputs except pc_saved, retry_count and fault_count SHALL be decoded from registered state only, with no combinational path from inputs.
REQ-025 Illegal state encodings SHALL return to IDLE at the next edge.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, pc_saved=RESET_PC, retry_count=0, flush counter=0, fault_count=0, recovery_en=0, pipeline_stall=0, fatal_error=0.
REQ-027 Reset asserted mid-episode (any state) SHALL abandon the episode; no recovery_en pulse SHALL follow deassertion.

Configuration
REQ-028 With RECOVERY_STATS_EN defined, fault_count SHALL increment on every fault accepted in IDLE or VERIFY and SHALL saturate at 16'hFFFF.
REQ-029 With RECOVERY_STATS_EN undefined, fault_count SHALL be tied to 16'h0000 and no counter logic SHALL be built.

Verification
REQ-030 Reset, then commit_valid with commit_pc=0x100 -> pc_saved=0x100 next cycle, state IDLE.
REQ-031 With pc_saved=0x100, fault pulse in IDLE -> stall for 2 cycles, recovery_en high 1 cycle on cycle 3 with pc_saved=0x100, then VERIFY; commit 0x104 -> IDLE, retry_count=0, pc_saved=0x104.
REQ-032 Fault repeated in VERIFY 3 times (MAX_RETRY=3) -> retry_count reaches 3, 4th fault -> FATAL with fatal_error=1; clear_fatal -> IDLE, retry_count=0.
REQ-033 fault_detected and commit_valid (0x200) together in IDLE -> FLUSH entered, pc_saved unchanged.
REQ-034 rst_n asserted during FLUSH -> immediate IDLE, all outputs at reset values, no recovery_en after release.
REQ-035 With RECOVERY_STATS_EN, 5 accepted faults -> fault_count=5; without it, fault_count=0.
